// File: rtl/face_overlay_writer_pkg.sv
// Shared constants and FSM state type for the face overlay writer.
package face_pkg;
    localparam int          NUM_CORES = 36;
    localparam int          ADDR_W    = 17;
    localparam int          DEPTH     = 100000;
    localparam int          PIX_W     = 32;
    localparam int unsigned FACE_VAL  = 255;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/face_overlay_writer_if.sv
// Memory-read and output-stream bundles of the face overlay writer.
interface face_overlay_mem_if
    import face_pkg::*;
();
    logic              mask_rd_en;
    logic [ADDR_W-1:0] mask_addr;
    logic              mask_bit;
    logic              pix_rd_en;
    logic [ADDR_W-1:0] pix_addr;
    logic [PIX_W-1:0]  pix_data;

    modport master (output mask_rd_en, mask_addr, pix_rd_en, pix_addr,
                    input  mask_bit, pix_data);
    modport slave  (input  mask_rd_en, mask_addr, pix_rd_en, pix_addr,
                    output mask_bit, pix_data);
endinterface

interface face_overlay_stream_if
    import face_pkg::*;
();
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pixel;
    logic             out_last;

    modport master (output out_valid, out_pixel, out_last, input out_ready);
    modport slave  (input  out_valid, out_pixel, out_last, output out_ready);
endinterface

// File: rtl/face_overlay_writer_skid_fifo.sv
// Two-entry FIFO between the memory read return and the output stream.
module overlay_skid_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic [1:0]   occ
);
    logic [W-1:0] mem_q [2];
    logic         wr_idx;
    logic         rd_idx;
    logic [1:0]   count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_idx <= ~wr_idx;
            if (pop)  rd_idx <= ~rd_idx;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_idx] <= din;
    end

    // Head is forced to zero when empty so stale data never reaches the port.
    assign valid = (count != 2'd0);
    assign dout  = valid ? mem_q[rd_idx] : '0;
    assign occ   = count;
endmodule

// File: rtl/face_overlay_writer.sv
// Waits for all cores, then streams the image with mask-marked pixels overwritten by FACE_VAL.
module face_overlay_writer
    import face_pkg::*;
#(
    parameter int MAX_PIX = DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CORES-1:0]  core_done,
    input  logic [31:0]           size,
    face_overlay_mem_if.master    mem_bus,
    face_overlay_stream_if.master out_bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  size_err
);
    localparam int CNT_W = ADDR_W + 1;

    state_t               state, state_nxt;
    logic [NUM_CORES-1:0] done_seen;
    logic                 all_done;
    logic [63:0]          area;
    logic [CNT_W-1:0]     total, rd_ptr, sent;
    logic                 rd_vld_p1;
    logic                 rd_issue, pop, last_beat, fifo_valid;
    logic [1:0]           occ;
    logic [2:0]           in_flight;
    logic [PIX_W-1:0]     entry_p1;

    assign all_done  = &(done_seen | core_done);
    assign area      = 64'(size) * 64'(size);
    assign pop       = fifo_valid & out_bus.out_ready;
    assign last_beat = pop && (sent == total - CNT_W'(1));

    // Credit includes this cycle's pop so a full pipe keeps one beat per cycle.
    assign in_flight = 3'(occ) + 3'(rd_vld_p1) - 3'(pop);
    assign rd_issue  = (state == RUN) && (rd_ptr < total) && (in_flight < 3'd2);

    assign mem_bus.mask_rd_en = rd_issue;
    assign mem_bus.pix_rd_en  = rd_issue;
    assign mem_bus.mask_addr  = rd_issue ? rd_ptr[ADDR_W-1:0] : '0;
    assign mem_bus.pix_addr   = rd_issue ? rd_ptr[ADDR_W-1:0] : '0;

    // Stage p1: read data returned one cycle after the strobe.
    assign entry_p1 = mem_bus.mask_bit ? PIX_W'(FACE_VAL) : mem_bus.pix_data;

    overlay_skid_fifo #(.W(PIX_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rd_vld_p1),
        .din   (entry_p1),
        .pop   (pop),
        .valid (fifo_valid),
        .dout  (out_bus.out_pixel),
        .occ   (occ)
    );

    assign out_bus.out_valid = fifo_valid;
    assign out_bus.out_last  = fifo_valid && (sent == total - CNT_W'(1));
    assign busy              = (state != IDLE);
    assign frame_done        = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (all_done) state_nxt = (area == 64'd0) ? DONE : RUN;
            RUN:  if (last_beat) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_seen <= '0;
            total     <= '0;
            rd_ptr    <= '0;
            sent      <= '0;
            rd_vld_p1 <= 1'b0;
            size_err  <= 1'b0;
        end else begin
            rd_vld_p1 <= rd_issue;
            if (state == IDLE && all_done) begin
                done_seen <= '0;
                rd_ptr    <= '0;
                sent      <= '0;
                if (area > 64'(MAX_PIX)) begin
                    total    <= CNT_W'(MAX_PIX);
                    size_err <= 1'b1;
                end else begin
                    total <= CNT_W'(area);
                end
            end else begin
                done_seen <= done_seen | core_done;
                if (rd_issue) rd_ptr <= rd_ptr + CNT_W'(1);
                if (pop)      sent   <= sent + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_face_overlay_writer.sv
// Scoreboard bench for face_overlay_writer with a small frame-depth limit.
module tb_face_overlay_writer;
    import face_pkg::*;

    localparam int TB_DEPTH = 64;

    typedef struct packed {
        logic [31:0] pix;
        logic        last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NUM_CORES-1:0] core_done = '0;
    logic [31:0]          size = 32'd0;
    logic                 busy, frame_done, size_err;

    face_overlay_mem_if    mem_bus ();
    face_overlay_stream_if out_bus ();

    logic mask_mem [0:127];
    exp_t sb [$];
    int   n_checks = 0;
    int   n_bad = 0;

    face_overlay_writer #(.MAX_PIX(TB_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_done  (core_done),
        .size       (size),
        .mem_bus    (mem_bus.master),
        .out_bus    (out_bus.master),
        .busy       (busy),
        .frame_done (frame_done),
        .size_err   (size_err)
    );

    always #5 clk = ~clk;

    initial begin
        mem_bus.mask_bit = 1'b0;
        mem_bus.pix_data = '0;
        out_bus.out_ready = 1'b1;
    end

    // Memory model: data appears the cycle after the strobe; pixel value equals address.
    always @(posedge clk) begin
        if (mem_bus.mask_rd_en) begin
            mem_bus.mask_bit <= mask_mem[mem_bus.mask_addr[6:0]];
            mem_bus.pix_data <= 32'(mem_bus.pix_addr);
        end
    end

    task automatic set_mask(input int kind);
        for (int a = 0; a < 128; a++) begin
            case (kind)
                0: mask_mem[a] = 1'b0;
                1: mask_mem[a] = (a == 5 || a == 6 || a == 9 || a == 10);
                2: mask_mem[a] = a[0];
                default: mask_mem[a] = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic fill_expected(input int n);
        exp_t e;
        for (int a = 0; a < n; a++) begin
            e.pix  = mask_mem[a] ? 32'd255 : 32'(a);
            e.last = (a == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic pulse_all();
        core_done = '1;
        @(negedge clk);
        core_done = '0;
    endtask

    // Drives out_ready per mode, checks each accepted beat against the scoreboard.
    task automatic run_frame(input int n, input int mode, input int stop_after,
                             input int max_cycles, output int span);
        int issued, accepted, first_cyc, last_cyc;
        logic pv, pr, pl;
        logic [31:0] pp;
        logic pat [4];
        exp_t e;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        issued = 0; accepted = 0; first_cyc = -1; last_cyc = -1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pp = '0;
        span = -1;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            if (mode == 0)      out_bus.out_ready = 1'b1;
            else if (cyc < 16)  out_bus.out_ready = pat[cyc % 4];
            else                out_bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (pv && !pr) begin
                n_checks++;
                if (!(out_bus.out_valid === 1'b1 && out_bus.out_pixel === pp && out_bus.out_last === pl)) begin
                    n_bad++;
                    $display("FAIL stall_hold cyc=%0d got v=%b pix=%0d last=%b want v=1 pix=%0d last=%b",
                             cyc, out_bus.out_valid, out_bus.out_pixel, out_bus.out_last, pp, pl);
                end
            end
            if (mem_bus.mask_rd_en) begin
                n_checks++;
                if (mem_bus.mask_addr !== 17'(issued) || mem_bus.pix_addr !== 17'(issued) ||
                    mem_bus.pix_rd_en !== 1'b1 || issued >= n) begin
                    n_bad++;
                    $display("FAIL read_addr got maddr=%0d paddr=%0d pen=%b want addr=%0d (< %0d)",
                             mem_bus.mask_addr, mem_bus.pix_addr, mem_bus.pix_rd_en, issued, n);
                end
                issued++;
            end
            if (out_bus.out_valid && out_bus.out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_beat got pix=%0d want no beat", out_bus.out_pixel);
                end else begin
                    e = sb.pop_front();
                    if (out_bus.out_pixel !== e.pix || out_bus.out_last !== e.last) begin
                        n_bad++;
                        $display("FAIL beat%0d got pix=%0d last=%b want pix=%0d last=%b",
                                 accepted, out_bus.out_pixel, out_bus.out_last, e.pix, e.last);
                    end
                end
                accepted++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            n_checks++;
            if (issued - accepted > 2 || frame_done !== 1'b0) begin
                n_bad++;
                $display("FAIL in_frame got inflight=%0d frame_done=%b want inflight<=2 frame_done=0",
                         issued - accepted, frame_done);
            end
            pv = out_bus.out_valid; pr = out_bus.out_ready;
            pp = out_bus.out_pixel; pl = out_bus.out_last;
            if (accepted == stop_after) return;
            @(negedge clk);
            if (accepted == n) break;
        end
        n_checks++;
        if (accepted != n) begin
            n_bad++;
            $display("FAIL frame_timeout got beats=%0d want %0d", accepted, n);
            return;
        end
        span = last_cyc - first_cyc;
        #1;
        n_checks++;
        if (frame_done !== 1'b1 || out_bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL done_pulse got frame_done=%b valid=%b want 1 0", frame_done, out_bus.out_valid);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL back_idle got frame_done=%b busy=%b want 0 0", frame_done, busy);
        end
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag, input logic want_err);
        n_checks++;
        if (out_bus.out_valid !== 1'b0 || mem_bus.mask_rd_en !== 1'b0 || mem_bus.pix_rd_en !== 1'b0 ||
            busy !== 1'b0 || frame_done !== 1'b0 || out_bus.out_pixel !== 32'd0 ||
            out_bus.out_last !== 1'b0 || size_err !== want_err) begin
            n_bad++;
            $display("FAIL %s got v=%b ren=%b pen=%b busy=%b fd=%b pix=%0d last=%b err=%b want zeros err=%b",
                     tag, out_bus.out_valid, mem_bus.mask_rd_en, mem_bus.pix_rd_en, busy, frame_done,
                     out_bus.out_pixel, out_bus.out_last, size_err, want_err);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_quiet("reset_held", 1'b0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_quiet("reset_release", 1'b0);
        @(negedge clk);
    endtask

    task automatic test_basic();
        int span;
        set_mask(1);
        size = 32'd4;
        fill_expected(16);
        pulse_all();
        #1;
        n_checks++;
        if (busy !== 1'b1 || mem_bus.mask_rd_en !== 1'b1 || out_bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_latency got busy=%b ren=%b valid=%b want 1 1 0",
                     busy, mem_bus.mask_rd_en, out_bus.out_valid);
        end
        run_frame(16, 0, -1, 100, span);
        n_checks++;
        if (span != 15) begin
            n_bad++;
            $display("FAIL basic_throughput got span=%0d want 15", span);
        end
    endtask

    task automatic test_staggered();
        int span;
        set_mask(2);
        size = 32'd4;
        fill_expected(16);
        for (int i = 0; i < NUM_CORES; i++) begin
            core_done = '0;
            core_done[i] = 1'b1;
            #1;
            n_checks++;
            if (mem_bus.mask_rd_en !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL stagger_early bit=%0d got ren=%b busy=%b want 0 0",
                         i, mem_bus.mask_rd_en, busy);
            end
            @(negedge clk);
        end
        core_done = '0;
        #1;
        n_checks++;
        if (busy !== 1'b1 || mem_bus.mask_rd_en !== 1'b1 || dut.done_seen !== '0) begin
            n_bad++;
            $display("FAIL stagger_start got busy=%b ren=%b done_seen=%h want 1 1 0",
                     busy, mem_bus.mask_rd_en, dut.done_seen);
        end
        run_frame(16, 0, -1, 100, span);
    endtask

    task automatic test_backpressure();
        int span;
        set_mask(3);
        size = 32'd4;
        fill_expected(16);
        pulse_all();
        run_frame(16, 1, -1, 300, span);
        out_bus.out_ready = 1'b1;
    endtask

    task automatic test_zero();
        size = 32'd0;
        pulse_all();
        #1;
        n_checks++;
        if (frame_done !== 1'b1 || busy !== 1'b1 || out_bus.out_valid !== 1'b0 || mem_bus.mask_rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_done got fd=%b busy=%b v=%b ren=%b want 1 1 0 0",
                     frame_done, busy, out_bus.out_valid, mem_bus.mask_rd_en);
        end
        @(negedge clk);
        #1;
        check_quiet("zero_idle", 1'b0);
        @(negedge clk);
    endtask

    task automatic test_depth_limits();
        int span;
        set_mask(3);
        size = 32'd8;
        fill_expected(TB_DEPTH);
        pulse_all();
        run_frame(TB_DEPTH, 0, -1, 200, span);
        n_checks++;
        if (size_err !== 1'b0) begin
            n_bad++;
            $display("FAIL exact_depth_err got %b want 0", size_err);
        end
        size = 32'd400;
        fill_expected(TB_DEPTH);
        pulse_all();
        #1;
        n_checks++;
        if (size_err !== 1'b1) begin
            n_bad++;
            $display("FAIL size_err_set got %b want 1", size_err);
        end
        run_frame(TB_DEPTH, 1, -1, 1000, span);
        out_bus.out_ready = 1'b1;
        n_checks++;
        if (size_err !== 1'b1) begin
            n_bad++;
            $display("FAIL size_err_sticky got %b want 1", size_err);
        end
    endtask

    task automatic test_reset_mid();
        int span;
        set_mask(1);
        size = 32'd4;
        fill_expected(16);
        pulse_all();
        run_frame(16, 0, 7, 100, span);
        #1;
        reset = 1'b1;
        #1;
        check_quiet("reset_mid", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        fill_expected(16);
        pulse_all();
        run_frame(16, 0, -1, 100, span);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_staggered();
        test_backpressure();
        test_zero();
        test_depth_limits();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
